dualport_ram_bist: RTL and testbench
====================================

Name: dualport_ram_bist

Overview:
- Self-test initiator that drives the write and read ports of the dual-port RAM (port 0 write, port 1 read) and checks the read data.
- Runs two passes, a true pattern then an inverted pattern, and reports pass/fail with first-error capture.
- Sits beside the RAM in integration and replaces the hand-written fill/readback sequence.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- DEPTH, 16, number of locations tested, addresses 0..DEPTH-1. Must satisfy 1 <= DEPTH <= 2^ADDR_WIDTH.
- READ_LATENCY, 1, edges from the RAM sampling addr_in_1 to valid data_out_1. Range 1..4.
- SEED, 1, pattern offset. Pattern(a) = (a + SEED) mod 2^DATA_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a test. Ignored unless the FSM is in IDLE or DONE.
- wr_en  out  1  RAM write enable.
- port_en_0  out  1  RAM port 0 enable.
- addr_in_0  out  ADDR_WIDTH  RAM write address.
- data_in  out  DATA_WIDTH  RAM write data.
- port_en_1  out  1  RAM port 1 enable.
- addr_in_1  out  ADDR_WIDTH  RAM read address.
- data_out_1  in  DATA_WIDTH  RAM read data.
- busy  out  1  test in progress.
- done  out  1  test finished. Held until the next accepted start or rst.
- fail  out  1  sticky mismatch flag. Meaningful when done=1.
- err_count  out  8  mismatch count, saturates at 255.
- err_addr  out  ADDR_WIDTH  address of the first mismatch.
- err_pass  out  1  pass of the first mismatch: 0 = true pattern, 1 = inverted.
- err_data  out  DATA_WIDTH  data read at the first mismatch.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; FSM = IDLE; counters 0.
- rst mid-test aborts the test. At the first edge with rst=1, every enable deasserts and all status outputs clear.
- FSM states and transitions:
  - IDLE: start moves the FSM to WRITE (pass=0, cnt=0) and clears all status.
  - WRITE: each cycle drives port_en_0=1, wr_en=1, addr_in_0=cnt, data_in=P(cnt). At cnt=DEPTH-1 the FSM moves to READ with cnt=0.
  - READ: each cycle drives port_en_1=1, addr_in_1=cnt. Pushes {expected=P(cnt), addr=cnt} into a compare pipeline of depth READ_LATENCY+1. At cnt=DEPTH-1 the FSM moves to DRAIN.
  - DRAIN: the FSM waits until the compare pipeline is empty. Then it goes to WRITE with pass=1, or to DONE if pass=1.
  - DONE: done=1 and busy=0. start restarts the test as from IDLE.
- P(a): true pass = (a+SEED) truncated to DATA_WIDTH; inverted pass = bitwise NOT of that value.
- Outside WRITE, wr_en, port_en_0, addr_in_0 and data_in are 0. Outside READ, port_en_1 and addr_in_1 are 0.
- busy=1 in WRITE, READ and DRAIN.
- Compare timing: for an address driven in the cycle after edge n, data_out_1 is sampled at edge n+1+READ_LATENCY.
- On mismatch: fail<=1 and err_count increments, saturating at 255. If this is the first mismatch, err_addr, err_pass and err_data latch.
- Both passes always run to completion; a mismatch never aborts the test.
- Latency: start sampled at edge E. The first write is addr 0 in the cycle after E. The inverted pass starts at edge E+2*DEPTH+READ_LATENCY. done rises after edge E+2*(2*DEPTH+READ_LATENCY); with defaults that is E+66.
- Address wrap: cnt stops at DEPTH-1 and never wraps. With DEPTH < 2^ADDR_WIDTH, upper addresses are never touched.
- start asserted while busy=1: ignored, no effect on the running test.
- start and rst together: rst wins.

Test Plan:
- Defaults, fault-free RAM, pulse start at edge E:
  - Write cycles show addr 0..15 with data 1..16.
  - Read cycles follow, then inverted data 0xFE..0xEF.
  - done=1 after edge E+66; fail=0; err_count=0; busy low from that edge.
- Defaults, bench forces data_out_1 bit 0 to 1 for all reads → err_count=16, with mismatches at all even-valued patterns in both passes. fail=1, err_pass=0, err_addr=1, err_data=8'h03.
- rst asserted at start+20 for one cycle → all enables are 0 and busy/done/fail are 0 after that edge. A new start then gives a clean 66-cycle run.
- start re-pulsed at start+10 while busy → ignored: no restart, done still rises at start+66.
- READ_LATENCY=3, DEPTH=8, SEED=0 → pattern 0..7 then 0xFF..0xF8. done rises after edge E+2*(16+3)=E+38; fail=0.
- Single-location error: bench corrupts only the read of addr 5 in the inverted pass → err_count=1, err_pass=1, err_addr=5, fail=1.

Source files
------------

// File: rtl/dualport_ram_bist_if.sv
// ----------------------------------------------------------------------------
// dualport_ram_bist_if
// Bundles the RAM-facing signals of the dual-port RAM self-test initiator.
//   Port 0 (write side): wr_en, port_en_0, addr_in_0, data_in
//   Port 1 (read side) : port_en_1, addr_in_1, data_out_1
// master : the BIST initiator (drives the enables, addresses and write data)
// slave  : the RAM (returns read data on data_out_1)
// ----------------------------------------------------------------------------
interface dualport_ram_bist_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic                  port_en_0;
  logic [ADDR_WIDTH-1:0] addr_in_0;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  port_en_1;
  logic [ADDR_WIDTH-1:0] addr_in_1;
  logic [DATA_WIDTH-1:0] data_out_1;

  modport master (
    output wr_en, port_en_0, addr_in_0, data_in,
    output port_en_1, addr_in_1,
    input  data_out_1
  );

  modport slave (
    input  wr_en, port_en_0, addr_in_0, data_in,
    input  port_en_1, addr_in_1,
    output data_out_1
  );
endinterface

// File: rtl/dualport_ram_bist.sv
// ----------------------------------------------------------------------------
// dualport_ram_bist
// Self-test initiator for a dual-port RAM (port 0 writes, port 1 reads).
// Runs a fill/readback pass with pattern P(a) = (a + SEED) mod 2^DATA_WIDTH,
// then a second pass with the bitwise-inverted pattern, and reports the
// result with capture of the first mismatch.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous, active-high reset (aborts a running test)
//   start      : one-cycle request, accepted only in IDLE or DONE
//   ram        : RAM bus (master side), see dualport_ram_bist_if
//   busy       : test in progress (WRITE, READ, DRAIN)
//   done       : test finished, held until the next accepted start or rst
//   fail       : sticky mismatch flag
//   err_count  : mismatch count, saturating at 255
//   err_addr   : address of the first mismatch
//   err_pass   : pass of the first mismatch (0 = true, 1 = inverted)
//   err_data   : data read at the first mismatch
//
// Parameters: 1 <= DEPTH <= 2**ADDR_WIDTH, 1 <= READ_LATENCY <= 4.
// All outputs are registered: they are loaded from the next-state values so
// that what appears on the bus in a cycle matches the state of that cycle.
// ----------------------------------------------------------------------------
module dualport_ram_bist #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 1,
  parameter int SEED         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  dualport_ram_bist_if.master   ram,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_pass,
  output logic [DATA_WIDTH-1:0] err_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state, nxt_state;
  logic [ADDR_WIDTH-1:0] cnt, nxt_cnt;
  logic                  pass, nxt_pass;
  logic                  clear_status;
  logic                  pipe_busy;

  // Compare pipeline: one stage per edge between pushing an address and
  // sampling its read data. Stage READ_LATENCY is the one being compared.
  logic [READ_LATENCY:0] pv;
  logic [DATA_WIDTH-1:0] pexp  [0:READ_LATENCY];
  logic [ADDR_WIDTH-1:0] paddr [0:READ_LATENCY];
  logic                  mismatch;

  // Test pattern for address a; the inverted pass uses the complement.
  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  inv
  );
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(a) + DATA_WIDTH'(SEED);
    return inv ? ~p : p;
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      pass  <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      pass  <= nxt_pass;
    end
  end

  // Entries still travelling towards the compare stage. The entry sitting in
  // the last stage is compared at this very edge, so it does not hold DRAIN.
  assign pipe_busy = |pv[READ_LATENCY-1:0];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every variable written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt;
    nxt_pass     = pass;
    clear_status = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          nxt_state    = S_WRITE;
          nxt_cnt      = '0;
          nxt_pass     = 1'b0;
          clear_status = 1'b1;
        end
      end
      S_WRITE: begin
        if (cnt == LAST_ADDR) begin
          nxt_state = S_READ;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      S_READ: begin
        if (cnt == LAST_ADDR) begin
          nxt_state = S_DRAIN;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!pipe_busy) begin
          if (pass) begin
            nxt_state = S_DONE;
          end else begin
            nxt_state = S_WRITE;
            nxt_pass  = 1'b1;
            nxt_cnt   = '0;
          end
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered RAM bus and handshake outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ram.wr_en     <= 1'b0;
      ram.port_en_0 <= 1'b0;
      ram.addr_in_0 <= '0;
      ram.data_in   <= '0;
      ram.port_en_1 <= 1'b0;
      ram.addr_in_1 <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      ram.wr_en     <= (nxt_state == S_WRITE);
      ram.port_en_0 <= (nxt_state == S_WRITE);
      ram.addr_in_0 <= (nxt_state == S_WRITE) ? nxt_cnt : '0;
      ram.data_in   <= (nxt_state == S_WRITE) ? pattern(nxt_cnt, nxt_pass) : '0;
      ram.port_en_1 <= (nxt_state == S_READ);
      ram.addr_in_1 <= (nxt_state == S_READ) ? nxt_cnt : '0;
      busy          <= (nxt_state == S_WRITE) || (nxt_state == S_READ) ||
                       (nxt_state == S_DRAIN);
      done          <= (nxt_state == S_DONE);
    end
  end

  // --------------------------------------------------------------------------
  // Compare pipeline
  // An entry is pushed at the edge that loads its address onto addr_in_1 and
  // reaches stage READ_LATENCY at the edge where its read data is valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv[0] <= (nxt_state == S_READ);
      for (int i = 1; i <= READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
      end
    end
  end

  // NOTE: the payload stages carry no reset; they are only ever looked at
  // behind their valid bit, so resetting them would add logic for nothing.
  always_ff @(posedge clk) begin
    pexp[0]  <= pattern(nxt_cnt, nxt_pass);
    paddr[0] <= nxt_cnt;
    for (int i = 1; i <= READ_LATENCY; i++) begin
      pexp[i]  <= pexp[i-1];
      paddr[i] <= paddr[i-1];
    end
  end

  assign mismatch = pv[READ_LATENCY] && (ram.data_out_1 != pexp[READ_LATENCY]);

  // --------------------------------------------------------------------------
  // Status and first-error capture
  // `pass` only changes at the edge that retires the final compare of a pass,
  // so its current value always names the pass of the entry being compared.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clear_status) begin
      fail      <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
      err_pass  <= 1'b0;
      err_data  <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
      if (!fail) begin
        err_addr <= paddr[READ_LATENCY];
        err_pass <= pass;
        err_data <= ram.data_out_1;
      end
    end
  end

endmodule

// File: tb/tb_dualport_ram_bist.sv
// ----------------------------------------------------------------------------
// tb_dualport_ram_bist
// Bench for dualport_ram_bist. DUT A uses the default parameters, DUT B uses
// READ_LATENCY=3, DEPTH=8, SEED=0. Each DUT is paired with a small RAM model
// of matching read latency; RAM A can force read bit 0 high or corrupt the
// inverted-pass read of address 5.
// ----------------------------------------------------------------------------
module tb_dualport_ram_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic force_bit0 = 1'b0;
  logic corrupt5 = 1'b0;

  always #5 clk = ~clk;

  dualport_ram_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) ifa ();
  dualport_ram_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) ifb ();

  logic       busy_a, done_a, fail_a, err_pass_a;
  logic [7:0] err_count_a, err_data_a;
  logic [3:0] err_addr_a;
  logic       busy_b, done_b, fail_b, err_pass_b;
  logic [7:0] err_count_b, err_data_b;
  logic [3:0] err_addr_b;

  dualport_ram_bist dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ram(ifa),
    .busy(busy_a), .done(done_a), .fail(fail_a), .err_count(err_count_a),
    .err_addr(err_addr_a), .err_pass(err_pass_a), .err_data(err_data_a)
  );

  dualport_ram_bist #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(8), .READ_LATENCY(3), .SEED(0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ram(ifb),
    .busy(busy_b), .done(done_b), .fail(fail_b), .err_count(err_count_b),
    .err_addr(err_addr_b), .err_pass(err_pass_b), .err_data(err_data_b)
  );

  // RAM A: one edge of read latency. Address 5 holds 0xF9 only in the
  // inverted pass, so its MSB selects that pass for the corruption fault.
  logic [7:0] mem_a [0:15];
  logic [7:0] rd_a;
  always @(posedge clk) begin
    if (ifa.port_en_0 && ifa.wr_en) mem_a[ifa.addr_in_0] <= ifa.data_in;
    if (ifa.port_en_1) begin
      if (corrupt5 && ifa.addr_in_1 == 4'd5 && mem_a[5][7])
        rd_a <= mem_a[5] ^ 8'h10;
      else
        rd_a <= mem_a[ifa.addr_in_1];
    end
  end
  assign ifa.data_out_1 = rd_a | {7'd0, force_bit0};

  // RAM B: three edges of read latency.
  logic [7:0] mem_b [0:15];
  logic [7:0] rd_b0, rd_b1, rd_b2;
  always @(posedge clk) begin
    if (ifb.port_en_0 && ifb.wr_en) mem_b[ifb.addr_in_0] <= ifb.data_in;
    rd_b0 <= mem_b[ifb.addr_in_1];
    rd_b1 <= rd_b0;
    rd_b2 <= rd_b1;
  end
  assign ifb.data_out_1 = rd_b2;

  // One snapshot of bus and handshake outputs, taken #1 after an edge.
  typedef struct packed {
    logic       wr_en;
    logic       pe0;
    logic [3:0] a0;
    logic [7:0] din;
    logic       pe1;
    logic [3:0] a1;
    logic       busy;
    logic       done;
    logic       fail;
  } bus_t;

  typedef struct {
    int   k;    // cycle after edge E+k
    bus_t exp;
  } vec_t;

  bus_t tr [0:79];
  vec_t tab_a [0:11];
  vec_t tab_b [0:11];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bus_t mk(input logic w, input logic [3:0] a0, input logic [7:0] d,
                              input logic r, input logic [3:0] a1,
                              input logic b, input logic dn, input logic f);
    bus_t s;
    s.wr_en = w;  s.pe0 = w;  s.a0 = a0; s.din = d;
    s.pe1 = r;    s.a1 = a1;  s.busy = b; s.done = dn; s.fail = f;
    return s;
  endfunction

  function automatic bus_t snap(input bit which);
    bus_t s;
    if (!which) begin
      s.wr_en = ifa.wr_en; s.pe0 = ifa.port_en_0; s.a0 = ifa.addr_in_0;
      s.din = ifa.data_in; s.pe1 = ifa.port_en_1; s.a1 = ifa.addr_in_1;
      s.busy = busy_a; s.done = done_a; s.fail = fail_a;
    end else begin
      s.wr_en = ifb.wr_en; s.pe0 = ifb.port_en_0; s.a0 = ifb.addr_in_0;
      s.din = ifb.data_in; s.pe1 = ifb.port_en_1; s.a1 = ifb.addr_in_1;
      s.busy = busy_b; s.done = done_b; s.fail = fail_b;
    end
    return s;
  endfunction

  // Pulse start so that it is sampled at edge E, then record ncyc snapshots
  // (tr[k] = state after edge E+k). start is re-pulsed before edge E+rp and
  // rst asserted for the single edge E+rk when those are positive.
  task automatic run_capture(input bit which, input int ncyc, input int rp, input int rk);
    @(negedge clk);
    if (!which) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    tr[0] = snap(which);
    for (int k = 1; k < ncyc; k++) begin
      if (k == rp || k == rk) begin
        @(negedge clk);
        if (k == rp) begin
          if (!which) start_a = 1'b1; else start_b = 1'b1;
        end
        if (k == rk) rst = 1'b1;
      end
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0; rst = 1'b0;
      tr[k] = snap(which);
    end
  endtask

  initial begin
    // Expected snapshots, default DUT, fault-free RAM.
    tab_a[0]  = '{0,  mk(1, 4'd0,  8'h01, 0, 4'd0,  1, 0, 0)};
    tab_a[1]  = '{15, mk(1, 4'd15, 8'h10, 0, 4'd0,  1, 0, 0)};
    tab_a[2]  = '{16, mk(0, 4'd0,  8'h00, 1, 4'd0,  1, 0, 0)};
    tab_a[3]  = '{31, mk(0, 4'd0,  8'h00, 1, 4'd15, 1, 0, 0)};
    tab_a[4]  = '{32, mk(0, 4'd0,  8'h00, 0, 4'd0,  1, 0, 0)};
    tab_a[5]  = '{33, mk(1, 4'd0,  8'hFE, 0, 4'd0,  1, 0, 0)};
    tab_a[6]  = '{48, mk(1, 4'd15, 8'hEF, 0, 4'd0,  1, 0, 0)};
    tab_a[7]  = '{49, mk(0, 4'd0,  8'h00, 1, 4'd0,  1, 0, 0)};
    tab_a[8]  = '{64, mk(0, 4'd0,  8'h00, 1, 4'd15, 1, 0, 0)};
    tab_a[9]  = '{65, mk(0, 4'd0,  8'h00, 0, 4'd0,  1, 0, 0)};
    tab_a[10] = '{66, mk(0, 4'd0,  8'h00, 0, 4'd0,  0, 1, 0)};
    tab_a[11] = '{69, mk(0, 4'd0,  8'h00, 0, 4'd0,  0, 1, 0)};
    // Expected snapshots, READ_LATENCY=3, DEPTH=8, SEED=0.
    tab_b[0]  = '{0,  mk(1, 4'd0, 8'h00, 0, 4'd0, 1, 0, 0)};
    tab_b[1]  = '{7,  mk(1, 4'd7, 8'h07, 0, 4'd0, 1, 0, 0)};
    tab_b[2]  = '{8,  mk(0, 4'd0, 8'h00, 1, 4'd0, 1, 0, 0)};
    tab_b[3]  = '{15, mk(0, 4'd0, 8'h00, 1, 4'd7, 1, 0, 0)};
    tab_b[4]  = '{16, mk(0, 4'd0, 8'h00, 0, 4'd0, 1, 0, 0)};
    tab_b[5]  = '{18, mk(0, 4'd0, 8'h00, 0, 4'd0, 1, 0, 0)};
    tab_b[6]  = '{19, mk(1, 4'd0, 8'hFF, 0, 4'd0, 1, 0, 0)};
    tab_b[7]  = '{26, mk(1, 4'd7, 8'hF8, 0, 4'd0, 1, 0, 0)};
    tab_b[8]  = '{27, mk(0, 4'd0, 8'h00, 1, 4'd0, 1, 0, 0)};
    tab_b[9]  = '{34, mk(0, 4'd0, 8'h00, 1, 4'd7, 1, 0, 0)};
    tab_b[10] = '{37, mk(0, 4'd0, 8'h00, 0, 4'd0, 1, 0, 0)};
    tab_b[11] = '{38, mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 1, 0)};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_bus_a", 32'(snap(1'b0)), 32'(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 0, 0)));
    check("reset_bus_b", 32'(snap(1'b1)), 32'(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 0, 0)));
    check("reset_err_count", 32'(err_count_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Default run, fault-free.
    run_capture(1'b0, 70, 0, 0);
    foreach (tab_a[i])
      check($sformatf("a_trace_k%0d", tab_a[i].k), 32'(tr[tab_a[i].k]), 32'(tab_a[i].exp));
    for (int a = 0; a < 16; a++) begin
      check($sformatf("a_wdata_true_%0d", a), 32'(tr[a].din), 32'(a + 1));
      check($sformatf("a_wdata_inv_%0d", a), 32'(tr[33 + a].din), 32'(8'hFE - 8'(a)));
      check($sformatf("a_raddr_%0d", a), 32'(tr[16 + a].a1), 32'(a));
    end
    check("a_clean_err_count", 32'(err_count_a), 32'd0);

    // Read bit 0 stuck high: even patterns mismatch in both passes.
    force_bit0 = 1'b1;
    run_capture(1'b0, 70, 0, 0);
    force_bit0 = 1'b0;
    check("bit0_done", 32'(done_a), 32'd1);
    check("bit0_fail", 32'(fail_a), 32'd1);
    check("bit0_err_count", 32'(err_count_a), 32'd16);
    check("bit0_err_addr", 32'(err_addr_a), 32'd1);
    check("bit0_err_pass", 32'(err_pass_a), 32'd0);
    check("bit0_err_data", 32'(err_data_a), 32'h03);

    // Restart from DONE clears status; start re-pulsed while busy is ignored.
    run_capture(1'b0, 70, 10, 0);
    check("repulse_status_cleared", 32'(tr[0].fail), 32'd0);
    check("repulse_k10", 32'(tr[10]), 32'(mk(1, 4'd10, 8'h0B, 0, 4'd0, 1, 0, 0)));
    check("repulse_done_65", 32'(tr[65].done), 32'd0);
    check("repulse_done_66", 32'(tr[66]), 32'(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 1, 0)));
    check("repulse_err_count", 32'(err_count_a), 32'd0);

    // Only the inverted-pass read of address 5 is corrupted.
    corrupt5 = 1'b1;
    run_capture(1'b0, 70, 0, 0);
    corrupt5 = 1'b0;
    check("c5_fail", 32'(fail_a), 32'd1);
    check("c5_err_count", 32'(err_count_a), 32'd1);
    check("c5_err_addr", 32'(err_addr_a), 32'd5);
    check("c5_err_pass", 32'(err_pass_a), 32'd1);
    check("c5_err_data", 32'(err_data_a), 32'hE9);

    // rst for one edge at E+20 aborts a run that already has an error.
    force_bit0 = 1'b1;
    run_capture(1'b0, 24, 0, 20);
    force_bit0 = 1'b0;
    check("rst_pre_busy", 32'(tr[19].busy), 32'd1);
    check("rst_pre_fail", 32'(tr[19].fail), 32'd1);
    check("rst_k20", 32'(tr[20]), 32'(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 0, 0)));
    check("rst_k23_idle", 32'(tr[23]), 32'(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 0, 0)));
    check("rst_err_count", 32'(err_count_a), 32'd0);

    // Clean run after the abort.
    run_capture(1'b0, 70, 0, 0);
    check("post_rst_k0", 32'(tr[0]), 32'(mk(1, 4'd0, 8'h01, 0, 4'd0, 1, 0, 0)));
    check("post_rst_done_65", 32'(tr[65].done), 32'd0);
    check("post_rst_done_66", 32'(tr[66]), 32'(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 1, 0)));

    // READ_LATENCY=3, DEPTH=8, SEED=0.
    run_capture(1'b1, 42, 0, 0);
    foreach (tab_b[i])
      check($sformatf("b_trace_k%0d", tab_b[i].k), 32'(tr[tab_b[i].k]), 32'(tab_b[i].exp));
    for (int a = 0; a < 8; a++) begin
      check($sformatf("b_wdata_true_%0d", a), 32'(tr[a].din), 32'(a));
      check($sformatf("b_wdata_inv_%0d", a), 32'(tr[19 + a].din), 32'(8'hFF - 8'(a)));
    end
    check("b_err_count", 32'(err_count_b), 32'd0);
    check("b_upper_addr_untouched", 32'(ifb.addr_in_0 | ifb.addr_in_1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
